// File: rtl/floppy_drive_gen_if.sv
// Signal bundle between the FDC core (master) and the virtual drive (slave).
// Controller side drives requests, geometry and media state; the drive returns strobe and status.
interface floppy_drive_gen_if;
    logic        select;
    logic        motor_on;
    logic        step_in;
    logic        step_out;
    logic [1:0]  density;
    logic [10:0] sector_len;
    logic [10:0] gap_len;
    logic [5:0]  spt;
    logic        sector_base;
    logic        inserted;
    logic        wp_in;

    logic        dclk_en;
    logic [6:0]  track;
    logic [5:0]  sector;
    logic        sector_hdr;
    logic        sector_data;
    logic        ready;
    logic        index;
    logic        track0;
    logic        wprot;
    logic        dskchg;

    modport master (
        output select, motor_on, step_in, step_out, density, sector_len, gap_len, spt,
               sector_base, inserted, wp_in,
        input  dclk_en, track, sector, sector_hdr, sector_data, ready, index, track0,
               wprot, dskchg
    );

    modport slave (
        input  select, motor_on, step_in, step_out, density, sector_len, gap_len, spt,
               sector_base, inserted, wp_in,
        output dclk_en, track, sector, sector_hdr, sector_data, ready, index, track0,
               wprot, dskchg
    );
endinterface

// File: rtl/floppy_drive_gen.sv
// Virtual floppy drive: spindle ramp, fractional byte clock, index, gap/header/data sequencer, head stepping.
// Strobe/status flops update one clock after their cause; ready/track0/wprot are combinational; no backpressure.
module floppy_drive_gen #(
    parameter int unsigned SYS_CLK     = 32000000,
    parameter int unsigned RPM         = 300,
    parameter int unsigned TRACKS      = 84,
    parameter int unsigned STEP_MS     = 18,
    parameter int unsigned SPINUP_MS   = 500,
    parameter int unsigned SPINDOWN_MS = 300,
    parameter int unsigned INDEX_MS    = 5,
    parameter int unsigned HDR_LEN     = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    floppy_drive_gen_if.slave bus
);
    typedef enum logic [1:0] {SEQ_GAP, SEQ_HDR, SEQ_DATA, SEQ_TAIL} seq_e;

    localparam logic [31:0] UP_RAW    = 32'((64'(SPINUP_MS) * 64'(SYS_CLK)) / 64'd64000);
    localparam logic [31:0] DN_RAW    = 32'((64'(SPINDOWN_MS) * 64'(SYS_CLK)) / 64'd64000);
    localparam logic [31:0] UP_IV     = (UP_RAW == 32'd0) ? 32'd1 : UP_RAW;
    localparam logic [31:0] DN_IV     = (DN_RAW == 32'd0) ? 32'd1 : DN_RAW;
    localparam logic [31:0] STEP_CLKS = 32'((64'(STEP_MS) * 64'(SYS_CLK)) / 64'd1000);
    localparam logic [31:0] IDX_CLKS  = 32'((64'(INDEX_MS) * 64'(SYS_CLK)) / 64'd1000);
    localparam logic [14:0] BPT_DD    = 15'((64'd250000 * 64'd60) / (64'd8 * 64'(RPM)));
    localparam logic [14:0] BPT_HD    = 15'((64'd500000 * 64'd60) / (64'd8 * 64'(RPM)));
    localparam logic [14:0] BPT_ED    = 15'((64'd1000000 * 64'd60) / (64'd8 * 64'(RPM)));
    localparam logic [6:0]  TRK_MAX   = 7'(TRACKS - 1);
    localparam logic [10:0] HDR_BYTES = 11'(HDR_LEN);
    localparam logic [32:0] SYS_CLK_W = 33'(SYS_CLK);

    logic [6:0]  lvl_q, lvl_d;
    logic [31:0] spin_cnt_q, spin_cnt_d;
    logic        motor_q, motor_d;
    logic [31:0] acc_q, acc_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [14:0] byte_cnt_q, byte_cnt_d;
    logic        dclk_en_q, dclk_en_d;
    logic [31:0] idx_cnt_q, idx_cnt_d;
    logic        index_q, index_d;
    seq_e        seq_q, seq_d;
    logic [10:0] rem_q, rem_d;
    logic        ld_q, ld_d;
    logic [5:0]  sec_idx_q, sec_idx_d;
    logic        hdr_q, hdr_d;
    logic        data_q, data_d;
    logic [1:0]  dens_q, dens_d;
    logic        step_in_s_q, step_in_s_d, step_in_p_q, step_in_p_d;
    logic        step_out_s_q, step_out_s_d, step_out_p_q, step_out_p_d;
    logic [6:0]  track_q, track_d;
    logic [31:0] busy_q, busy_d;
    logic        dskchg_q, dskchg_d;
    logic        ins_q, ins_d;

    logic        motor_eff, dens_chg, bit_tick, byte_tick, wrap;
    logic        ein, eout, step_acc;
    logic [31:0] rate_full, rate_cur;
    logic [32:0] acc_sum;
    logic [14:0] bpt;
    logic [10:0] len_cur, rem;
    logic [5:0]  last_idx;

    assign motor_eff = bus.motor_on && bus.select && bus.inserted;
    assign dens_chg  = bus.density != dens_q;

    always_comb begin
        rate_full = 32'd250000;
        bpt       = BPT_DD;
        case (bus.density)
            2'd1: begin rate_full = 32'd500000;  bpt = BPT_HD; end
            2'd2: begin rate_full = 32'd1000000; bpt = BPT_ED; end
            default: ;
        endcase
    end

    // Rate scales with spindle level; assumes the full rate never exceeds SYS_CLK.
    assign rate_cur  = 32'((64'(rate_full) * 64'(lvl_q)) >> 6);
    assign acc_sum   = {1'b0, acc_q} + {1'b0, rate_cur};
    assign bit_tick  = acc_sum >= SYS_CLK_W;
    assign byte_tick = bit_tick && (bit_cnt_q == 3'd7) && !dens_chg;
    assign wrap      = byte_tick && (byte_cnt_q >= bpt - 15'd1);

    always_comb begin
        len_cur = 11'd0;
        case (seq_q)
            SEQ_GAP:  len_cur = bus.gap_len;
            SEQ_HDR:  len_cur = HDR_BYTES;
            SEQ_DATA: len_cur = bus.sector_len;
            default:  len_cur = 11'd0;
        endcase
    end

    // ld_q marks a freshly entered state whose length has not been loaded yet.
    assign rem      = ld_q ? len_cur : rem_q;
    assign last_idx = bus.spt - 6'd1;

    assign ein      = step_in_s_q && !step_in_p_q;
    assign eout     = step_out_s_q && !step_out_p_q;
    assign step_acc = bus.select && (ein != eout);

    always_comb begin
        motor_d    = motor_eff;
        lvl_d      = lvl_q;
        spin_cnt_d = spin_cnt_q;
        if (motor_eff != motor_q) begin
            spin_cnt_d = 32'd0;
        end else if (motor_eff && (lvl_q < 7'd64)) begin
            if (spin_cnt_q >= UP_IV - 32'd1) begin
                lvl_d      = lvl_q + 7'd1;
                spin_cnt_d = 32'd0;
            end else begin
                spin_cnt_d = spin_cnt_q + 32'd1;
            end
        end else if (!motor_eff && (lvl_q != 7'd0)) begin
            if (spin_cnt_q >= DN_IV - 32'd1) begin
                lvl_d      = lvl_q - 7'd1;
                spin_cnt_d = 32'd0;
            end else begin
                spin_cnt_d = spin_cnt_q + 32'd1;
            end
        end else begin
            spin_cnt_d = 32'd0;
        end

        bit_cnt_d = bit_cnt_q;
        acc_d     = acc_sum[31:0];
        if (bit_tick) begin
            acc_d     = 32'(acc_sum - SYS_CLK_W);
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        byte_cnt_d = byte_cnt_q;
        if (byte_tick) begin
            byte_cnt_d = wrap ? 15'd0 : byte_cnt_q + 15'd1;
        end
        dclk_en_d = byte_tick;

        idx_cnt_d = (idx_cnt_q != 32'd0) ? idx_cnt_q - 32'd1 : 32'd0;
        if (wrap) begin
            idx_cnt_d = IDX_CLKS;
        end
        index_d = idx_cnt_d != 32'd0;

        seq_d     = seq_q;
        rem_d     = rem_q;
        ld_d      = ld_q;
        sec_idx_d = sec_idx_q;
        if (byte_tick && (seq_q != SEQ_TAIL)) begin
            if (rem > 11'd1) begin
                rem_d = rem - 11'd1;
                ld_d  = 1'b0;
            end else begin
                ld_d = 1'b1;
                case (seq_q)
                    SEQ_GAP: seq_d = SEQ_HDR;
                    SEQ_HDR: seq_d = SEQ_DATA;
                    default: begin
                        if (sec_idx_q == last_idx) begin
                            seq_d = SEQ_TAIL;
                        end else begin
                            seq_d     = SEQ_GAP;
                            sec_idx_d = sec_idx_q + 6'd1;
                        end
                    end
                endcase
            end
        end
        // A new revolution or a density switch abandons whatever sector was in flight.
        if (wrap || dens_chg) begin
            seq_d     = SEQ_GAP;
            sec_idx_d = 6'd0;
            ld_d      = 1'b1;
        end
        if (dens_chg) begin
            acc_d      = 32'd0;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 15'd0;
        end
        hdr_d  = seq_d == SEQ_HDR;
        data_d = seq_d == SEQ_DATA;
        dens_d = bus.density;

        step_in_s_d  = bus.step_in;
        step_in_p_d  = step_in_s_q;
        step_out_s_d = bus.step_out;
        step_out_p_d = step_out_s_q;
        busy_d   = (busy_q != 32'd0) ? busy_q - 32'd1 : 32'd0;
        track_d  = track_q;
        dskchg_d = dskchg_q;
        if (step_acc) begin
            busy_d = STEP_CLKS;
            if (ein && (track_q < TRK_MAX)) begin
                track_d = track_q + 7'd1;
            end else if (eout && (track_q != 7'd0)) begin
                track_d = track_q - 7'd1;
            end
            if (bus.inserted) begin
                dskchg_d = 1'b0;
            end
        end
        if (ins_q && !bus.inserted) begin
            dskchg_d = 1'b1;
        end
        ins_d = bus.inserted;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q        <= 7'd0;
            spin_cnt_q   <= 32'd0;
            motor_q      <= 1'b0;
            acc_q        <= 32'd0;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 15'd0;
            dclk_en_q    <= 1'b0;
            idx_cnt_q    <= 32'd0;
            index_q      <= 1'b0;
            seq_q        <= SEQ_GAP;
            rem_q        <= 11'd0;
            ld_q         <= 1'b1;
            sec_idx_q    <= 6'd0;
            hdr_q        <= 1'b0;
            data_q       <= 1'b0;
            dens_q       <= 2'd0;
            step_in_s_q  <= 1'b0;
            step_in_p_q  <= 1'b0;
            step_out_s_q <= 1'b0;
            step_out_p_q <= 1'b0;
            track_q      <= 7'd0;
            busy_q       <= 32'd0;
            dskchg_q     <= 1'b1;
            ins_q        <= 1'b0;
        end else begin
            lvl_q        <= lvl_d;
            spin_cnt_q   <= spin_cnt_d;
            motor_q      <= motor_d;
            acc_q        <= acc_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            dclk_en_q    <= dclk_en_d;
            idx_cnt_q    <= idx_cnt_d;
            index_q      <= index_d;
            seq_q        <= seq_d;
            rem_q        <= rem_d;
            ld_q         <= ld_d;
            sec_idx_q    <= sec_idx_d;
            hdr_q        <= hdr_d;
            data_q       <= data_d;
            dens_q       <= dens_d;
            step_in_s_q  <= step_in_s_d;
            step_in_p_q  <= step_in_p_d;
            step_out_s_q <= step_out_s_d;
            step_out_p_q <= step_out_p_d;
            track_q      <= track_d;
            busy_q       <= busy_d;
            dskchg_q     <= dskchg_d;
            ins_q        <= ins_d;
        end
    end

    assign bus.dclk_en     = dclk_en_q;
    assign bus.track       = track_q;
    assign bus.sector      = sec_idx_q + {5'd0, bus.sector_base};
    assign bus.sector_hdr  = hdr_q;
    assign bus.sector_data = data_q;
    assign bus.index       = index_q;
    assign bus.dskchg      = dskchg_q;
    assign bus.ready       = bus.select && bus.inserted && (lvl_q == 7'd64) && (busy_q == 32'd0);
    assign bus.track0      = bus.select && (track_q == 7'd0);
    assign bus.wprot       = bus.wp_in || !bus.inserted;
endmodule

// File: tb/tb_floppy_drive_gen.sv
// Directed bench for floppy_drive_gen on a scaled clock: 2 MHz, 37500 rpm gives 50/100/200 bytes per track.
// DD byte = 64 clks, HD = 32, ED = 16; ramp step 31 clks; step busy and index width 2000 clks.
module tb_floppy_drive_gen;
    localparam int unsigned SYS_CLK = 2000000;
    localparam int BPT  = 50;
    localparam int GAP  = 4;
    localparam int HDR  = 2;
    localparam int SLEN = 8;
    localparam int SPT  = 3;
    localparam int BASE = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    floppy_drive_gen_if ifc ();

    floppy_drive_gen #(
        .SYS_CLK(SYS_CLK), .RPM(37500), .TRACKS(84), .STEP_MS(1), .SPINUP_MS(1),
        .SPINDOWN_MS(1), .INDEX_MS(1), .HDR_LEN(HDR)
    ) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_dclk(input int limit, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!ifc.dclk_en && n < limit);
    endtask

    task automatic pulse(input logic pin, input logic pout);
        ifc.step_in  = pin;
        ifc.step_out = pout;
        tick(2);
        ifc.step_in  = 1'b0;
        ifc.step_out = 1'b0;
        tick(2);
    endtask

    // Expected {sector, hdr, data} for a byte position within the track.
    function automatic logic [7:0] map_exp(input int pos);
        int per, s, off;
        logic h, d;
        per = GAP + HDR + SLEN;
        if (pos >= SPT * per) return {6'(BASE + SPT - 1), 2'b00};
        s   = pos / per;
        off = pos % per;
        h   = (off >= GAP) && (off < GAP + HDR);
        d   = off >= GAP + HDR;
        return {6'(BASE + s), h, d};
    endfunction

    function automatic logic [7:0] obs();
        return {ifc.sector, ifc.sector_hdr, ifc.sector_data};
    endfunction

    initial begin
        int n, k, pos, fall, rise;
        logic prev;

        ifc.select = 1'b0;  ifc.motor_on = 1'b0; ifc.step_in = 1'b0; ifc.step_out = 1'b0;
        ifc.density = 2'd0; ifc.sector_len = 11'(SLEN); ifc.gap_len = 11'(GAP);
        ifc.spt = 6'(SPT);  ifc.sector_base = 1'(BASE); ifc.inserted = 1'b1; ifc.wp_in = 1'b0;
        tick(3);

        check("rst_dclk", ifc.dclk_en, 0);
        check("rst_index", ifc.index, 0);
        check("rst_track", ifc.track, 0);
        check("rst_map", obs(), {6'd1, 2'b00});
        check("rst_ready", ifc.ready, 0);
        check("rst_dskchg", ifc.dskchg, 1);
        check("rst_wprot", ifc.wprot, 0);
        check("rst_track0_desel", ifc.track0, 0);
        ifc.select = 1'b1;
        #1;
        check("rst_track0_sel", ifc.track0, 1);

        // Spin-up: ready after 64 level steps of 31 clocks.
        reset_n = 1'b1;
        ifc.motor_on = 1'b1;
        n = 0;
        while (!ifc.ready && n < 5000) begin
            tick(1);
            n++;
        end
        check("spinup_window", (n >= 63 * 31) && (n <= 65 * 31), 1);

        wait_dclk(200, n);
        for (int i = 0; i < 3; i++) begin
            wait_dclk(200, n);
            check("dd_interval", n, 64);
        end

        // One full revolution from an index rising edge.
        prev = ifc.index;
        n = 0;
        do begin
            prev = ifc.index;
            tick(1);
            n++;
        end while (!(ifc.index && !prev) && n < 8000);
        check("index_rise_seen", ifc.index, 1);
        check("map_after_index", obs(), map_exp(0));
        pos = 0; fall = -1; rise = -1; prev = 1'b1;
        for (int c = 1; c <= 3300; c++) begin
            tick(1);
            if (ifc.dclk_en) begin
                pos = (pos + 1) % BPT;
                check($sformatf("map_pos%0d", pos), obs(), map_exp(pos));
            end
            if (!ifc.index && fall < 0) fall = c;
            if (ifc.index && !prev && rise < 0) rise = c;
            prev = ifc.index;
        end
        check("index_width", fall, 2000);
        check("index_period", rise, 3200);

        // Density switch while inside sector 2 data, then HD->ED inside sector 1 data.
        n = 0;
        while (!(ifc.sector_data && ifc.sector == 6'd2) && n < 4000) begin
            tick(1);
            n++;
        end
        check("mid_data_dd", ifc.sector_data, 1);
        ifc.density = 2'd1;
        tick(1);
        check("hd_clear_map", obs(), {6'(BASE), 2'b00});
        check("hd_clear_dclk", ifc.dclk_en, 0);
        wait_dclk(200, n);
        check("hd_first", n, 32);
        wait_dclk(200, n);
        check("hd_interval", n, 32);
        k = 2;
        while (!ifc.sector_hdr && k < 20) begin
            wait_dclk(200, n);
            k++;
        end
        check("hd_hdr_byte", k, GAP);
        while (!ifc.sector_data && k < 20) begin
            wait_dclk(200, n);
            k++;
        end
        check("hd_data_byte", k, GAP + HDR);
        ifc.density = 2'd2;
        tick(1);
        check("ed_clear_map", obs(), {6'(BASE), 2'b00});
        wait_dclk(200, n);
        check("ed_first", n, 16);
        wait_dclk(200, n);
        check("ed_interval", n, 16);

        // Stepping: clamped step_out at track 0 still reloads busy.
        ifc.step_out = 1'b1;
        tick(1);
        check("step_lat1_ready", ifc.ready, 1);
        tick(1);
        check("step_lat2_ready", ifc.ready, 0);
        check("step_out_clamp", ifc.track, 0);
        check("dskchg_cleared", ifc.dskchg, 0);
        ifc.step_out = 1'b0;
        n = 0;
        while (!ifc.ready && n < 3000) begin
            tick(1);
            n++;
        end
        check("busy_len", n, 2000);

        ifc.step_in = 1'b1;
        tick(1);
        check("step_in_lat1", ifc.track, 0);
        tick(1);
        check("step_in_lat2", ifc.track, 1);
        ifc.step_in = 1'b0;
        tick(2);
        for (int i = 0; i < 89; i++) pulse(1'b1, 1'b0);
        check("step_in_clamp", ifc.track, 83);
        check("track0_off", ifc.track0, 0);

        n = 0;
        while (!ifc.ready && n < 3000) begin
            tick(1);
            n++;
        end
        check("ready_before_simul", ifc.ready, 1);
        pulse(1'b1, 1'b1);
        check("simul_track", ifc.track, 83);
        check("simul_no_busy", ifc.ready, 1);
        pulse(1'b0, 1'b1);
        check("step_out_move", ifc.track, 82);
        ifc.select = 1'b0;
        pulse(1'b1, 1'b0);
        check("desel_no_move", ifc.track, 82);
        ifc.select = 1'b1;

        // Disk change.
        ifc.inserted = 1'b0;
        tick(1);
        check("eject_dskchg", ifc.dskchg, 1);
        check("eject_ready", ifc.ready, 0);
        check("eject_wprot", ifc.wprot, 1);
        ifc.inserted = 1'b1;
        tick(2);
        check("reinsert_dskchg", ifc.dskchg, 1);
        pulse(1'b1, 1'b0);
        check("step_clears_dskchg", ifc.dskchg, 0);
        check("step_after_insert", ifc.track, 83);

        // Asynchronous reset in the middle of a data field.
        n = 0;
        while (!ifc.sector_data && n < 20000) begin
            tick(1);
            n++;
        end
        check("pre_reset_data", ifc.sector_data, 1);
        reset_n = 1'b0;
        #2;
        check("areset_dclk", ifc.dclk_en, 0);
        check("areset_index", ifc.index, 0);
        check("areset_track", ifc.track, 0);
        check("areset_map", obs(), {6'(BASE), 2'b00});
        check("areset_dskchg", ifc.dskchg, 1);
        check("areset_ready", ifc.ready, 0);
        check("areset_track0", ifc.track0, 1);
        tick(3);
        reset_n = 1'b1;
        wait_dclk(6000, n);
        check("post_reset_first_strobe", (n >= 16) && (n < 6000), 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
